// File: rtl/soc_timer_pkg.sv
// Shared definitions for the SoC timer peripheral.
// Latency: none (types, constants and a pure byte-merge helper).
// Backpressure: not applicable.
package soc_timer_pkg;

    // Register indices decoded from addr[3:2]
    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_PRESC = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_CMP   = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_IE   = 2;
    localparam int CTRL_PEND = 8;

    // Bus slave handshake state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    // Merge write data into the current value, one byte lane per enable bit
    function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/soc_timer_presc.sv
// Prescaler: counts enabled cycles and emits a tick when the count equals the reload value.
// Latency: tick is combinational from the registered count; count wraps to 0 on tick.
// Backpressure: none; en=0 freezes the count, clr forces it to 0.
module soc_timer_presc #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [PRESC_W-1:0] reload,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en && (pcnt == reload);

    // Prescale counter: clear on PRESC write, otherwise count while enabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            if (pcnt == reload) pcnt <= '0;
            else                pcnt <= pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/soc_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match and level interrupt.
// Latency: bus req -> ack one cycle; interrupt request rises the cycle after a match tick.
// Backpressure: none; one access per req/ack pair, req ignored while ack is high.
module soc_timer
    import soc_timer_pkg::*;
#(
    parameter int          PRESC_W = 16,
    parameter logic [31:0] RST_CMP = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        int_req_o,
    input  logic        int_fin_i
);

    bus_state_t state, state_nxt;
    logic       access;

    logic               ctrl_en, ctrl_ar, ctrl_ie, pend;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        count, cmp;

    logic [1:0]  idx;
    logic        wr_en, rd_en;
    logic        wr_ctrl, wr_presc, wr_count, wr_cmp;
    logic [31:0] ctrl_rd, presc_ext, presc_new, rd_mux;
    logic        tick, match, pend_clr;
    logic        unused_bits;

    assign idx      = bus_addr[3:2];
    assign wr_en    = access && bus_we;
    assign rd_en    = access && !bus_we;
    assign wr_ctrl  = wr_en && (idx == REG_CTRL);
    assign wr_presc = wr_en && (idx == REG_PRESC);
    assign wr_count = wr_en && (idx == REG_COUNT);
    assign wr_cmp   = wr_en && (idx == REG_CMP);

    assign bus_ack   = (state == ST_ACK);
    assign int_req_o = pend && ctrl_ie;

    assign ctrl_rd   = {23'd0, pend, 5'd0, ctrl_ie, ctrl_ar, ctrl_en};
    assign presc_ext = 32'(presc);
    assign presc_new = apply_be(presc_ext, bus_wdata, bus_be);

    // Compare is evaluated on the pre-write COUNT so a same-cycle bus write cannot hide a match
    assign match    = tick && (count == cmp);
    assign pend_clr = (int_fin_i && int_req_o) ||
                      (wr_ctrl && bus_be[1] && bus_wdata[CTRL_PEND]);

    // Address bits outside the register window and PRESC bits above PRESC_W are don't-care
    assign unused_bits = ^{bus_addr[31:4], bus_addr[1:0], presc_new[31:PRESC_W]};

    soc_timer_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk    (clk),
        .rstn   (rstn),
        .en     (ctrl_en),
        .reload (presc),
        .clr    (wr_presc),
        .tick   (tick)
    );

    // Bus FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Bus FSM next state: accept in IDLE, spend exactly one cycle in ACK
    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus_req) begin
                    access    = 1'b1;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read data mux over the register file
    always_comb begin
        rd_mux = 32'd0;
        case (idx)
            REG_CTRL:  rd_mux = ctrl_rd;
            REG_PRESC: rd_mux = presc_ext;
            REG_COUNT: rd_mux = count;
            REG_CMP:   rd_mux = cmp;
            default:   rd_mux = 32'd0;
        endcase
    end

    // Read data captured on a read access and held until the next one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      bus_rdata <= 32'd0;
        else if (rd_en) bus_rdata <= rd_mux;
    end

    // CTRL control bits live in byte 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_en <= 1'b0;
            ctrl_ar <= 1'b0;
            ctrl_ie <= 1'b0;
        end else if (wr_ctrl && bus_be[0]) begin
            ctrl_en <= bus_wdata[CTRL_EN];
            ctrl_ar <= bus_wdata[CTRL_AR];
            ctrl_ie <= bus_wdata[CTRL_IE];
        end
    end

    // Pending flag: a new match beats any clear in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pend <= 1'b0;
        else       pend <= match || (pend && !pend_clr);
    end

    // Prescaler reload register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         presc <= '0;
        else if (wr_presc) presc <= presc_new[PRESC_W-1:0];
    end

    // Main counter: bus write has priority over a tick
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= 32'd0;
        end else if (wr_count) begin
            count <= apply_be(count, bus_wdata, bus_be);
        end else if (tick) begin
            if (match && ctrl_ar) count <= 32'd0;
            else                  count <= count + 32'd1;
        end
    end

    // Compare register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       cmp <= RST_CMP;
        else if (wr_cmp) cmp <= apply_be(cmp, bus_wdata, bus_be);
    end

endmodule
